conv_mem_read_seq: RTL



---
 rtl/conv_mem_read_seq.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/conv_mem_read_seq.sv
// Read-side sequencer for the ping-pong image/kernel buffers: pairs full banks and sweeps all address pairs.
// Optional `CONV_MEM_SEQ_STALL_CNT_EN adds a saturating stall_cycles counter output.
`timescale 1ns/1ps
module conv_mem_read_seq #(
  parameter int IMAGE_MEM_DEPTH_BITS  = 13,
  parameter int KERNEL_MEM_DEPTH_BITS = 9
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             img_wr_done,
  input  logic                             img_wr_bank,
  input  logic [IMAGE_MEM_DEPTH_BITS-1:0]  img_last_addr,
  input  logic                             ker_wr_done,
  input  logic                             ker_wr_bank,
  input  logic [KERNEL_MEM_DEPTH_BITS-1:0] ker_last_addr,
  output logic [1:0]                       img_bank_full,
  output logic [1:0]                       ker_bank_full,
  output logic [IMAGE_MEM_DEPTH_BITS-1:0]  img_read_address,
  output logic                             img_select_block_rd,
  output logic [KERNEL_MEM_DEPTH_BITS-1:0] ker_read_address,
  output logic                             ker_select_block_rd,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_first,
  output logic                             out_last,
  output logic                             pass_done,
  output logic                             busy,
  output logic                             err_overwrite
`ifdef CONV_MEM_SEQ_STALL_CNT_EN
  ,
  output logic [31:0]                      stall_cycles
`endif
);

  localparam int IW = IMAGE_MEM_DEPTH_BITS;
  localparam int KW = KERNEL_MEM_DEPTH_BITS;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_RELEASE} state_t;

  state_t          r_state, w_next;
  logic [1:0]      r_img_full, r_ker_full;
  logic [IW-1:0]   r_img_last [2];
  logic [KW-1:0]   r_ker_last [2];
  logic            r_rp_img, r_rp_ker;
  logic [IW-1:0]   r_i, r_disp_i;
  logic [KW-1:0]   r_k, r_disp_k;
  logic            r_valid, r_first, r_last, r_pass_done, r_err;

  logic [IW-1:0]   w_img_lim;
  logic [KW-1:0]   w_ker_lim;
  logic            w_go, w_stall, w_k_end, w_i_end, w_end, w_issue;
  logic [IW-1:0]   w_rd_i;
  logic [KW-1:0]   w_rd_k;

  assign w_img_lim = r_img_last[r_rp_img];
  assign w_ker_lim = r_ker_last[r_rp_ker];
  assign w_go      = r_img_full[r_rp_img] & r_ker_full[r_rp_ker];
  assign w_stall   = r_valid & ~out_ready;
  assign w_k_end   = (r_k == w_ker_lim);
  assign w_i_end   = (r_i == w_img_lim);
  assign w_end     = w_k_end & w_i_end;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // A single-beat pass has already issued its only beat on leaving IDLE, so it goes straight to DRAIN.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (w_go) w_next = w_end ? S_DRAIN : S_RUN;
      S_RUN:     if (!w_stall && w_end) w_next = S_DRAIN;
      S_DRAIN:   if (r_valid && out_ready) w_next = S_RELEASE;
      S_RELEASE: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // While a beat is stalled the RAM re-reads the displayed address so its data stays put.
  always_comb begin
    w_issue = 1'b0;
    if (r_state == S_IDLE && w_go)    w_issue = 1'b1;
    if (r_state == S_RUN && !w_stall) w_issue = 1'b1;
    w_rd_i = w_stall ? r_disp_i : r_i;
    w_rd_k = w_stall ? r_disp_k : r_k;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_img_full    <= '0;
      r_ker_full    <= '0;
      r_img_last[0] <= '0;
      r_img_last[1] <= '0;
      r_ker_last[0] <= '0;
      r_ker_last[1] <= '0;
      r_rp_img      <= 1'b0;
      r_rp_ker      <= 1'b0;
      r_i           <= '0;
      r_k           <= '0;
      r_disp_i      <= '0;
      r_disp_k      <= '0;
      r_valid       <= 1'b0;
      r_first       <= 1'b0;
      r_last        <= 1'b0;
      r_pass_done   <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_pass_done <= (r_state == S_RELEASE);

      if (w_issue) begin
        r_valid  <= 1'b1;
        r_disp_i <= r_i;
        r_disp_k <= r_k;
        r_first  <= (r_i == '0) && (r_k == '0);
        r_last   <= w_end;
        if (!w_end) begin
          if (w_k_end) begin
            r_k <= '0;
            r_i <= r_i + 1'b1;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end

      if (r_state == S_RELEASE) begin
        r_img_full[r_rp_img] <= 1'b0;
        r_ker_full[r_rp_ker] <= 1'b0;
        r_rp_img             <= ~r_rp_img;
        r_rp_ker             <= ~r_rp_ker;
        r_i                  <= '0;
        r_k                  <= '0;
      end

      // A bank being released this cycle still counts as full for the writer.
      if (img_wr_done) begin
        if (r_img_full[img_wr_bank] || (r_state == S_RELEASE && img_wr_bank == r_rp_img)) begin
          r_err <= 1'b1;
        end else begin
          r_img_full[img_wr_bank] <= 1'b1;
          r_img_last[img_wr_bank] <= img_last_addr;
        end
      end
      if (ker_wr_done) begin
        if (r_ker_full[ker_wr_bank] || (r_state == S_RELEASE && ker_wr_bank == r_rp_ker)) begin
          r_err <= 1'b1;
        end else begin
          r_ker_full[ker_wr_bank] <= 1'b1;
          r_ker_last[ker_wr_bank] <= ker_last_addr;
        end
      end
    end
  end

`ifdef CONV_MEM_SEQ_STALL_CNT_EN
  logic [31:0] r_stall_cnt;
  always_ff @(posedge clk) begin
    if (reset)                          r_stall_cnt <= '0;
    else if (w_stall && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 32'd1;
  end
  assign stall_cycles = r_stall_cnt;
`endif

  assign img_bank_full       = r_img_full;
  assign ker_bank_full       = r_ker_full;
  assign img_read_address    = w_rd_i;
  assign ker_read_address    = w_rd_k;
  assign img_select_block_rd = r_rp_img;
  assign ker_select_block_rd = r_rp_ker;
  assign out_valid           = r_valid;
  assign out_first           = r_valid & r_first;
  assign out_last            = r_valid & r_last;
  assign pass_done           = r_pass_done;
  assign busy                = (r_state != S_IDLE);
  assign err_overwrite       = r_err;

endmodule
